ram_copier: RTL
===============

RAM_COPIER -- requirements
Module: ram_copier

Interface
REQ-001 The block SHALL have parameter AddrSize, default `DefaultAddrSize, meaning the RAM address width.
REQ-002 The block SHALL have parameter WordSize, default `DefaultWordSize, meaning the RAM data word width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, on ports: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have the following control ports:
- start  input  1  request a copy; sampled on the rising edge in IDLE only.
- src  input  AddrSize  first source address.
- dst  input  AddrSize  first destination address.
- len  input  AddrSize+1  number of words to copy; range 0..2^AddrSize.
REQ-005 The block SHALL have the following RAM-side ports:
- mem_address  output  AddrSize  drives the ram address input.
- mem_in  output  WordSize  drives the ram in input.
- mem_load  output  1  drives the ram load input.
- mem_out  input  WordSize  the ram out input; data is valid one cycle after the address is presented.
REQ-006 The block SHALL have the following status ports:
- busy  output  1  high while a copy is in progress.
- done  output  1  one-cycle pulse when a copy completes.
- checksum  output  WordSize  running sum of the words copied (see Configuration).

Function
REQ-007 The state machine SHALL have the states IDLE, READ, WRITE and DONE.
REQ-008 In IDLE, start=1 at a rising edge SHALL latch src, dst and len into the internal registers src_ptr, dst_ptr and count, then transition:
- to READ if len != 0;
- to DONE if len == 0.
REQ-009 The address outputs SHALL be driven combinationally from the state and internal registers only, with no combinational path from any input:
- READ: mem_address=src_ptr, mem_load=0.
- WRITE: mem_address=dst_ptr, mem_in=mem_out, mem_load=1.
- IDLE and DONE: mem_address=0, mem_in=0, mem_load=0.
REQ-010 READ SHALL always transition to WRITE on the next edge; this cycle covers the ram's one-cycle read latency.
REQ-011 On each WRITE edge the block SHALL:
- increment src_ptr and dst_ptr by 1, modulo 2^AddrSize (addresses wrap from 2^AddrSize-1 to 0);
- decrement count;
- go to DONE if count reaches 0, else go to READ.
REQ-012 A copy of N words SHALL take exactly 2N cycles in READ/WRITE, followed by one DONE cycle.
REQ-013 busy SHALL be 1 in READ and WRITE, and 0 in IDLE and DONE.
REQ-014 done SHALL be 1 only in DONE; DONE SHALL always return to IDLE on the next edge.
REQ-015 start SHALL be ignored in READ, WRITE and DONE; a start asserted in the DONE cycle is dropped.
REQ-016 Changes to src, dst or len after start is accepted SHALL NOT affect the copy in progress.
REQ-017 Overlapping regions SHALL be copied strictly in ascending address order, one word at a time; no memmove correction is applied.
REQ-018 When len = 2^AddrSize, the entire memory SHALL be copied and count SHALL reach 0 without overflow.

Reset
REQ-019 Asserting reset SHALL immediately, without waiting for a clock edge, force:
- state=IDLE; src_ptr, dst_ptr, count and checksum to 0;
- busy=0, done=0, mem_load=0.
REQ-020 A reset during WRITE SHALL deassert mem_load before the next edge, so no write occurs; words already written stay written.
REQ-021 After reset is released, the block SHALL accept start on the first rising edge.

Configuration
REQ-022 When the macro RAM_COPY_CHECKSUM_EN is defined:
- checksum SHALL be cleared when start is accepted;
- on every WRITE edge, mem_out SHALL be added to checksum, modulo 2^WordSize;
- checksum SHALL hold its value through DONE and IDLE.
REQ-023 When RAM_COPY_CHECKSUM_EN is not defined, checksum SHALL be constant 0 and no accumulator logic SHALL be synthesized.

Verification
REQ-024 Basic copy: mem[4..6]=11,22,33; start with src=4, dst=20, len=3 -> mem[20..22]=11,22,33; busy high for 6 cycles; done pulses once; checksum=66 with macro defined, 0 without.
REQ-025 Zero length: start with len=0 -> DONE on the next cycle; done=1 for one cycle; mem_load never asserted; busy never asserted.
REQ-026 Wrap-around with AddrSize=4: start with src=14, dst=2, len=4 -> reads addresses 14, 15, 0, 1 into mem[2..5].
REQ-027 Overlap: mem[0]=A, mem[1]=B; start with src=0, dst=1, len=2 -> mem[1]=A and mem[2]=A.
REQ-028 Ignored start: start held high for the whole copy and through the DONE cycle -> exactly one copy is performed and the block ends in IDLE.
REQ-029 Reset mid-copy: assert reset during the second WRITE cycle of a len=5 copy -> mem_load=0 immediately; only one word is written; busy=0; a new start is accepted after reset is released.

Source files
------------

// File: rtl/ram_copier.sv
// ram_copier: copies len words from src to dst in a single-port RAM that has a one-cycle read latency
// Ports: clk, reset (async, active-high); start/src/dst/len request a copy;
//   mem_address/mem_in/mem_load drive the RAM, mem_out is its registered read data;
//   busy is high during READ/WRITE, done pulses in DONE, checksum is the sum of the copied words.
// Define RAM_COPY_CHECKSUM_EN to build the checksum accumulator; otherwise checksum is tied to 0.
`ifndef DefaultAddrSize
`define DefaultAddrSize 8
`endif
`ifndef DefaultWordSize
`define DefaultWordSize 8
`endif
module ram_copier #(
  parameter int AddrSize = `DefaultAddrSize,
  parameter int WordSize = `DefaultWordSize
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [AddrSize-1:0] src,
  input  logic [AddrSize-1:0] dst,
  input  logic [AddrSize:0]   len,
  output logic [AddrSize-1:0] mem_address,
  output logic [WordSize-1:0] mem_in,
  output logic                mem_load,
  input  logic [WordSize-1:0] mem_out,
  output logic                busy,
  output logic                done,
  output logic [WordSize-1:0] checksum
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [AddrSize-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic [AddrSize:0] count_q, count_d;
  logic accept;
  always_comb begin
    accept = state_q == IDLE && start;
    state_d = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (start) begin
        src_ptr_d = src;
        dst_ptr_d = dst;
        count_d = len;
        state_d = len == '0 ? DONE : READ;
      end
      READ: state_d = WRITE;
      WRITE: begin
        src_ptr_d = src_ptr_q + 1'b1;
        dst_ptr_d = dst_ptr_q + 1'b1;
        count_d = count_q - 1'b1;
        state_d = count_d == '0 ? DONE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      count_q <= count_d;
    end
  end
  // Outputs decode the registered state only, so an async reset drops mem_load at once.
  assign mem_address = state_q == READ ? src_ptr_q : state_q == WRITE ? dst_ptr_q : '0;
  assign mem_in = state_q == WRITE ? mem_out : '0;
  assign mem_load = state_q == WRITE;
  assign busy = state_q == READ || state_q == WRITE;
  assign done = state_q == DONE;
`ifdef RAM_COPY_CHECKSUM_EN
  logic [WordSize-1:0] checksum_q, checksum_d;
  always_comb checksum_d = accept ? '0 : state_q == WRITE ? checksum_q + mem_out : checksum_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) checksum_q <= '0;
    else checksum_q <= checksum_d;
  end
  assign checksum = checksum_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign checksum = '0;
`endif
endmodule
